instr_fetch_responder: RTL
==========================

// Module: instr_fetch_responder
// PURPOSE
//   Accepts 64-bit instruction addresses from the program counter over a valid/ready handshake.
//   Fetches the addressed 32-bit word from a word-wide instruction memory with variable read latency.
//   Returns the instruction, or a fault code, to the decode stage over a second valid/ready handshake.
//   Sits between the PC register and decode; one fetch outstanding at a time.
// PARAMETERS
//   MEM_WORDS  1024   instruction memory depth in 32-bit words
//   ADDR_W     10     memory word-address width; must equal clog2(MEM_WORDS)
//   BASE_ADDR  64'h0  byte address mapped to memory word 0
// PORTS
//   clk          in   1   clock, all state updates on rising edge
//   rst_n        in   1   synchronous active-low reset
//   flush        in   1   abandon in-flight fetch / pending response
//   pc_valid     in   1   pc_addr valid
//   pc_addr      in   64  byte address of instruction
//   pc_ready     out  1   responder can accept an address this cycle
//   mem_rd_en    out  1   one-cycle read strobe to instruction memory
//   mem_addr     out  ADDR_W  word address, (pc_addr-BASE_ADDR)>>2
//   mem_rd_valid in   1   read data valid, at least 1 cycle after mem_rd_en
//   mem_rd_data  in   32  read data
//   ins_valid    out  1   instruction response valid
//   ins_data     out  32  instruction word; 32'hD503201F (NOP) on fault
//   ins_addr     out  64  pc_addr captured for this response
//   ins_fault    out  2   00 ok, 01 misaligned (pc_addr[1:0]!=0), 10 out of range
//   ins_ready    in   1   decode accepts response
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): state IDLE.
//     All outputs 0, except pc_ready=1 in IDLE after reset.
//     Captured address/data cleared. A mem_rd_valid arriving after reset is ignored.
//   - States: IDLE, REQ, WAIT, RESP, DRAIN.
//   - pc_ready = !flush && (IDLE || (RESP && ins_ready)).
//     An accept occurs when pc_valid && pc_ready.
//   - Accept: capture pc_addr and classify it.
//     - Misaligned takes priority over out of range.
//     - Out of range when (pc_addr-BASE_ADDR) >= MEM_WORDS*4 (unsigned 64-bit).
//     - Also out of range when pc_addr < BASE_ADDR, through wrap of the unsigned subtract.
//   - Accept with fault: go to RESP next cycle.
//     ins_data=NOP, ins_fault set, no memory access.
//   - Accept without fault: go to REQ.
//     - REQ: mem_rd_en=1 for exactly that cycle; mem_addr is held stable from REQ until data returns.
//     - Then WAIT.
//   - WAIT: when mem_rd_valid, latch mem_rd_data and go to RESP with ins_fault=00.
//     Latency from accept to ins_valid is 3 cycles with 1-cycle memory.
//   - RESP: ins_valid=1. ins_data/ins_addr/ins_fault stable until ins_ready.
//     - ins_ready && !pc_valid -> IDLE.
//     - ins_ready && pc_valid -> back-to-back accept, same edge.
//   - mem_rd_valid outside WAIT/DRAIN is ignored.
//   - flush (highest priority after reset):
//     - IDLE/RESP -> IDLE; ins_valid deasserts next cycle; no accept that cycle.
//     - REQ (strobe already issued this cycle) or WAIT without mem_rd_valid -> DRAIN.
//     - WAIT with mem_rd_valid that cycle -> IDLE, data discarded.
//   - DRAIN: pc_ready=0. Wait for mem_rd_valid, discard the data, then IDLE.
//     flush in DRAIN has no further effect.
//   - Reset mid-fetch: immediate IDLE. The memory must tolerate the abandoned read.
// TESTING
//   - Reset: hold rst_n=0 2 cycles with pc_valid=1.
//     -> ins_valid=0, mem_rd_en=0. pc_ready=1 the cycle after release.
//   - Normal fetch: pc_addr=0x8, mem returns 0x8B020020 1 cycle after strobe.
//     -> mem_addr=2, ins_valid 3 cycles after accept, ins_data=0x8B020020, fault=00.
//   - Faults:
//     - pc_addr=0x6 -> fault=01, NOP, no mem_rd_en.
//     - pc_addr=0x1000 (MEM_WORDS=1024) -> fault=10.
//   - Backpressure/back-to-back: hold ins_ready=0 5 cycles -> outputs stable.
//     Then ins_ready=1 with pc_valid=1 (0xC) -> same-edge accept, next mem_rd_en has mem_addr=3.
//   - Flush in WAIT with 4-cycle memory: pc_ready stays 0 until the stale data returns.
//     Stale data never appears on ins_data; the next fetch of 0x10 returns the correct word.
//   - Flush while ins_valid=1 and pc_valid=1: no accept, ins_valid=0 next cycle, pc_ready=1 after.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: takes a PC byte address, reads one 32-bit word
// from a variable-latency instruction memory and hands the instruction (or a
// fault code with a NOP) to decode. One fetch outstanding at a time.
module instr_fetch_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              pc_valid,
  input  logic [63:0]       pc_addr,
  output logic              pc_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic              ins_valid,
  output logic [31:0]       ins_data,
  output logic [63:0]       ins_addr,
  output logic [1:0]        ins_fault,
  input  logic              ins_ready
);

  localparam logic [63:0] MEM_BYTES      = 64'(MEM_WORDS) << 2;
  localparam logic [31:0] NOP_INSN       = 32'hD503201F;
  localparam logic [1:0]  FAULT_OK       = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_RANGE    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        fault_q, fault_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;

  logic [63:0] offset;
  logic        accept;

  // Next-state, capture and handshake logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    fault_d  = fault_q;
    maddr_d  = maddr_q;
    offset   = pc_addr - BASE_ADDR;
    pc_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_RESP) && ins_ready));
    accept   = pc_valid && pc_ready;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_REQ: begin
        // Strobe has already gone out this cycle, so a flush must drain it
        state_d = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            data_d  = mem_rd_data;
            fault_d = FAULT_OK;
            state_d = S_RESP;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_RESP: begin
        if (flush || ins_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mem_rd_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // New address accepted (from IDLE, or back-to-back out of RESP)
    if (accept) begin
      addr_d = pc_addr;
      if (pc_addr[1:0] != 2'b00) begin
        fault_d = FAULT_MISALIGN;
        data_d  = NOP_INSN;
        state_d = S_RESP;
      end else if (offset >= MEM_BYTES) begin
        fault_d = FAULT_RANGE;
        data_d  = NOP_INSN;
        state_d = S_RESP;
      end else begin
        fault_d = FAULT_OK;
        maddr_d = offset[ADDR_W+1:2];
        state_d = S_REQ;
      end
    end
  end

  // State and capture registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      fault_q <= '0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      maddr_q <= maddr_d;
    end
  end

  assign mem_rd_en = (state_q == S_REQ);
  assign mem_addr  = maddr_q;
  assign ins_valid = (state_q == S_RESP);
  assign ins_data  = data_q;
  assign ins_addr  = addr_q;
  assign ins_fault = fault_q;

endmodule
